matmul_operand_sequencer: RTL and testbench
===========================================

// Module: matmul_operand_sequencer
// PURPOSE
// Upstream feeder/collector for the matmul_core MAC. Holds square DIM_P x DIM_P
// operand matrices A and B, loaded via a write port. On start, drives one
// (a,b) pair per cycle and the accumulator clear for each output element C[i][j].
// Each C[i][j] = sum_k A[i][k]*B[k][j] is captured from the core and presented
// downstream on a valid/ready port in row-major order.
// PARAMETERS
// DIM_P        4   matrix dimension N (N x N operands, N >= 2)
// WIDTH_P      8   signed operand width; matches core WIDTH_P
// ACC_WIDTH_P  32  signed accumulator/result width; matches core ACC_WIDTH_P
// PORTS
// clk_i             in   1            clock, all state on rising edge
// reset_ni          in   1            asynchronous, active-low reset
// wr_en_i           in   1            operand write strobe
// wr_sel_i          in   1            0 = matrix A, 1 = matrix B
// wr_addr_i         in   $clog2(N*N)  row-major element index (row*N+col)
// wr_data_i         in   WIDTH_P      signed element value
// start_i           in   1            begin full multiply (sampled in IDLE only)
// busy_o            out  1            high in any state other than IDLE
// done_o            out  1            1-cycle pulse after last result accepted
// core_acc_clear_o  out  1            to core acc_clear_i
// core_valid_o      out  1            to core valid_i
// core_a_o          out  WIDTH_P      to core a_i (A[i][k])
// core_b_o          out  WIDTH_P      to core b_i (B[k][j])
// core_result_i     in   ACC_WIDTH_P  from core result_o
// res_valid_o       out  1            result available
// res_ready_i       in   1            downstream accepts result
// res_data_o        out  ACC_WIDTH_P  C[i][j]
// res_row_o         out  $clog2(N)    i of presented result
// res_col_o         out  $clog2(N)    j of presented result
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; i,j,k counters 0; all
//   outputs 0. Operand storage is NOT reset (contents undefined until written).
// - Writes take effect at the clock edge in IDLE only; ignored while busy_o=1.
//   Out-of-range wr_addr_i (>= N*N) is ignored.
// - FSM: IDLE -> CLEAR -> FEED -> DRAIN -> OUT -> (CLEAR | IDLE).
//   IDLE:  start_i=1 -> CLEAR with i=j=0. start_i while busy is ignored.
//   CLEAR: 1 cycle, core_acc_clear_o=1, core_valid_o=0; k<=0; -> FEED.
//   FEED:  N cycles, core_valid_o=1, core_a_o=A[i][k], core_b_o=B[k][j],
//          k increments; after k=N-1 -> DRAIN. Outputs driven from registers
//          or storage combinationally from current i,j,k (no extra latency).
//   DRAIN: 1 cycle, core_valid_o=0; core_result_i now holds final sum; it is
//          registered into res_data_o at end of cycle; -> OUT.
//   OUT:   res_valid_o=1; data/row/col stable until res_ready_i=1 at an edge.
//          On accept: if (i,j)=(N-1,N-1) -> IDLE and done_o=1 next cycle;
//          else advance j (wrap to 0 with i+1) -> CLEAR.
// - core_valid_o and core_acc_clear_o never high together; both 0 outside
//   CLEAR/FEED. core_a_o/core_b_o are 0 when core_valid_o=0.
// - Per-element latency N+3 cycles with res_ready_i held high; full matrix
//   N*N*(N+3) cycles from start to last accept; done_o the cycle after.
// - res_ready_i outside OUT has no effect. Core ready_o not consumed (always 1).
// - Reset mid-operation: abort immediately, return to IDLE, no done_o pulse.
// - Width rules: res_data_o = core_result_i unmodified (overflow wraps in core).
// TESTING
// 1 Reset: reset_ni=0 mid-FEED -> all outputs 0, busy_o=0, IDLE next cycle.
// 2 A=identity, B[r][c]=r*N+c, N=4, ready=1 -> 16 results, C==B, row-major,
//   each 7 cycles apart, done_o pulse 1 cycle after 16th accept.
// 3 A,B all -128 (N=4) -> every C = 65536; A=127,B=-128 -> every C = -65024.
// 4 Backpressure: res_ready_i=0 for 10 cycles on C[0][1] -> res_valid_o and
//   data/row/col held stable, core_valid_o=0 throughout, no result lost.
// 5 Writes/start while busy: wr_en_i to A[0] and start_i during FEED ->
//   results unchanged, no restart; same write after done_o takes effect.
// 6 Protocol check every cycle: never (core_valid_o & core_acc_clear_o);
//   exactly N core_valid_o cycles between consecutive core_acc_clear_o pulses.

Source files
------------

// File: rtl/matmul_operand_sequencer_if.sv
// Bundle of operand-write, control, core-side and result-side signals for
// matmul_operand_sequencer. The sequencer connects through the slave modport.
interface matmul_operand_sequencer_if #(
    parameter int DIM_P       = 4,
    parameter int WIDTH_P     = 8,
    parameter int ACC_WIDTH_P = 32
);
    localparam int AW = $clog2(DIM_P * DIM_P);
    localparam int IW = $clog2(DIM_P);

    logic                          wr_en_i;
    logic                          wr_sel_i;
    logic [AW-1:0]                 wr_addr_i;
    logic signed [WIDTH_P-1:0]     wr_data_i;
    logic                          start_i;
    logic                          busy_o;
    logic                          done_o;
    logic                          core_acc_clear_o;
    logic                          core_valid_o;
    logic signed [WIDTH_P-1:0]     core_a_o;
    logic signed [WIDTH_P-1:0]     core_b_o;
    logic signed [ACC_WIDTH_P-1:0] core_result_i;
    // Result handshake: a result transfers on a rising edge where res_valid_o
    // and res_ready_i are both high; while valid waits, data/row/col stay fixed.
    logic                          res_valid_o;
    logic                          res_ready_i;
    logic signed [ACC_WIDTH_P-1:0] res_data_o;
    logic [IW-1:0]                 res_row_o;
    logic [IW-1:0]                 res_col_o;
    logic [2:0]                    state_dbg_o;

    modport slave (
        input  wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
        input  core_result_i, res_ready_i,
        output busy_o, done_o, core_acc_clear_o, core_valid_o, core_a_o, core_b_o,
        output res_valid_o, res_data_o, res_row_o, res_col_o, state_dbg_o
    );

    modport master (
        output wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
        output core_result_i, res_ready_i,
        input  busy_o, done_o, core_acc_clear_o, core_valid_o, core_a_o, core_b_o,
        input  res_valid_o, res_data_o, res_row_o, res_col_o, state_dbg_o
    );
endinterface

// File: rtl/matmul_operand_sequencer.sv
// Operand store and element sequencer for the matmul_core MAC: feeds one
// (A[i][k], B[k][j]) pair per cycle and hands each C[i][j] downstream.
module matmul_operand_sequencer #(
    parameter int DIM_P       = 4,
    parameter int WIDTH_P     = 8,
    parameter int ACC_WIDTH_P = 32
) (
    input logic                          clk_i,
    input logic                          reset_ni,
    matmul_operand_sequencer_if.slave    bus
);
    localparam int NN = DIM_P * DIM_P;
    localparam int AW = $clog2(NN);
    localparam int IW = $clog2(DIM_P);
    localparam logic [IW-1:0] LAST = IW'(DIM_P - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    state_e                        state_q, state_d;
    logic [IW-1:0]                 i_q, i_d;
    logic [IW-1:0]                 j_q, j_d;
    logic [IW-1:0]                 k_q, k_d;
    logic signed [ACC_WIDTH_P-1:0] res_data_q, res_data_d;
    logic                          done_q, done_d;

    // Operand storage carries no reset; contents are defined only once written.
    logic signed [WIDTH_P-1:0] a_mem_q [NN];
    logic signed [WIDTH_P-1:0] b_mem_q [NN];
    logic                      wr_ok;
    logic [AW-1:0]             a_idx;
    logic [AW-1:0]             b_idx;
    logic                      feeding;

    assign wr_ok = bus.wr_en_i && (state_q == ST_IDLE) && (int'(bus.wr_addr_i) < NN);

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            if (bus.wr_sel_i) begin
                b_mem_q[bus.wr_addr_i] <= bus.wr_data_i;
            end else begin
                a_mem_q[bus.wr_addr_i] <= bus.wr_data_i;
            end
        end
    end

    assign a_idx   = AW'(int'(i_q) * DIM_P + int'(k_q));
    assign b_idx   = AW'(int'(k_q) * DIM_P + int'(j_q));
    assign feeding = (state_q == ST_FEED);

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        res_data_d = res_data_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_CLEAR;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ST_CLEAR: begin
                k_d     = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                k_d = k_q + 1'b1;
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The core's accumulator has absorbed the last product by now.
                res_data_d = bus.core_result_i;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (bus.res_ready_i) begin
                    if ((i_q == LAST) && (j_q == LAST)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        i_d     = '0;
                        j_d     = '0;
                    end else if (j_q == LAST) begin
                        j_d     = '0;
                        i_d     = i_q + 1'b1;
                        state_d = ST_CLEAR;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            res_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            res_data_q <= res_data_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy_o           = (state_q != ST_IDLE);
    assign bus.done_o           = done_q;
    assign bus.core_acc_clear_o = (state_q == ST_CLEAR);
    assign bus.core_valid_o     = feeding;
    assign bus.core_a_o         = feeding ? a_mem_q[a_idx] : '0;
    assign bus.core_b_o         = feeding ? b_mem_q[b_idx] : '0;
    assign bus.res_valid_o      = (state_q == ST_OUT);
    assign bus.res_data_o       = res_data_q;
    assign bus.res_row_o        = i_q;
    assign bus.res_col_o        = j_q;
    assign bus.state_dbg_o      = state_q;
endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Bench for matmul_operand_sequencer: behavioural MAC core, matrix-product
// reference model, per-feature scenario tasks and a per-cycle protocol monitor.
module tb_matmul_operand_sequencer;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int ACC = 32;
    localparam int IW  = $clog2(N);
    localparam int AW  = $clog2(N * N);
    localparam int RW  = ACC + 2 * IW;
    localparam int OW  = 4 + 2 * W + 1 + ACC + 2 * IW;
    localparam int PER = N + 3;

    logic clk      = 1'b0;
    logic reset_ni = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    matmul_operand_sequencer_if #(.DIM_P(N), .WIDTH_P(W), .ACC_WIDTH_P(ACC)) bus ();

    matmul_operand_sequencer #(.DIM_P(N), .WIDTH_P(W), .ACC_WIDTH_P(ACC)) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .bus      (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // ---------------- behavioural MAC core ----------------
    int core_acc;
    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni)                  core_acc <= 0;
        else if (bus.core_acc_clear_o)  core_acc <= 0;
        else if (bus.core_valid_o)      core_acc <= core_acc + int'(bus.core_a_o) * int'(bus.core_b_o);
    end
    assign bus.core_result_i = core_acc;

    // ---------------- reference model ----------------
    logic signed [W-1:0] ref_a [N*N];
    logic signed [W-1:0] ref_b [N*N];
    logic [RW-1:0]       exp_q [$];

    function automatic void build_exp();
        int s;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += int'(ref_a[i*N+k]) * int'(ref_b[k*N+j]);
                exp_q.push_back({IW'(i), IW'(j), ACC'(s)});
            end
        end
    endfunction

    function automatic void fill_random();
        for (int x = 0; x < N * N; x++) begin
            ref_a[x] = W'($urandom_range(0, 255));
            ref_b[x] = W'($urandom_range(0, 255));
        end
    endfunction

    // ---------------- protocol monitor ----------------
    int mon_vcnt   = 0;
    bit mon_seen_c = 0;
    always @(negedge clk) begin
        if (!reset_ni) begin
            mon_vcnt   = 0;
            mon_seen_c = 0;
        end else begin
            checks++;
            if (bus.core_valid_o === 1'b1 && bus.core_acc_clear_o === 1'b1) begin
                errors++;
                $display("FAIL proto_overlap: got valid=1 clear=1, expected never both at %0t", $time);
            end
            checks++;
            if (bus.core_valid_o !== 1'b1 && {bus.core_a_o, bus.core_b_o} !== '0) begin
                errors++;
                $display("FAIL proto_idle_ab: got a=%0d b=%0d, expected 0 when not valid", bus.core_a_o, bus.core_b_o);
            end
            if (bus.core_acc_clear_o === 1'b1) begin
                if (mon_seen_c) begin
                    checks++;
                    if (mon_vcnt != N) begin
                        errors++;
                        $display("FAIL proto_feed_len: got %0d valid cycles, expected %0d", mon_vcnt, N);
                    end
                end
                mon_seen_c = 1;
                mon_vcnt   = 0;
            end
            if (bus.core_valid_o === 1'b1) mon_vcnt++;
        end
    end

    // ---------------- driver tasks ----------------
    logic [RW-1:0]       obs_q [$];
    int                  acc_cyc_q [$];
    int                  done_cycle;
    int                  done_pulses;
    bit                  timed_out;
    int                  hold_viol;
    int                  busy_viol;
    logic signed [W-1:0] poke_val;

    task automatic write_elem(input bit sel, input int addr, input logic signed [W-1:0] data);
        @(negedge clk);
        bus.wr_en_i   = 1'b1;
        bus.wr_sel_i  = sel;
        bus.wr_addr_i = AW'(addr);
        bus.wr_data_i = data;
        @(negedge clk);
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic load_mats();
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < N * N; x++) begin
                @(negedge clk);
                bus.wr_en_i   = 1'b1;
                bus.wr_sel_i  = s[0];
                bus.wr_addr_i = AW'(x);
                bus.wr_data_i = (s == 0) ? ref_a[x] : ref_b[x];
            end
        end
        @(negedge clk);
        bus.wr_en_i = 1'b0;
    endtask

    // Runs one full multiply; e counts rising edges since the start edge.
    task automatic run_mult(input int stall_idx, input int stall_len, input bit rand_ready, input bit poke);
        int            e;
        int            stall_left;
        int            post;
        bit            poked;
        bit            holding;
        logic [RW-1:0] held;
        logic [RW-1:0] cur;
        obs_q.delete();
        acc_cyc_q.delete();
        done_cycle  = -1;
        done_pulses = 0;
        timed_out   = 0;
        hold_viol   = 0;
        busy_viol   = 0;
        stall_left  = stall_len;
        post        = -1;
        poked       = 0;
        holding     = 0;
        held        = '0;
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        e = 0;
        forever begin
            bus.wr_en_i = 1'b0;
            bus.start_i = 1'b0;
            if (bus.done_o === 1'b1) begin
                done_pulses++;
                if (done_cycle < 0) begin
                    done_cycle = e;
                    post       = 0;
                end
            end
            if (post < 0 && bus.busy_o !== 1'b1) busy_viol++;
            if (post > 0 && bus.busy_o !== 1'b0) busy_viol++;
            if (post >= 3) break;
            if (post >= 0) post++;
            if (e > 3000) begin
                timed_out = 1;
                break;
            end
            if (poke && !poked && bus.core_valid_o === 1'b1) begin
                bus.wr_en_i   = 1'b1;
                bus.wr_sel_i  = 1'b0;
                bus.wr_addr_i = '0;
                bus.wr_data_i = poke_val;
                bus.start_i   = 1'b1;
                poked         = 1;
            end
            cur = {bus.res_row_o, bus.res_col_o, bus.res_data_o};
            if (bus.res_valid_o === 1'b1) begin
                if (obs_q.size() == stall_idx && stall_left > 0) begin
                    if (!holding) begin
                        held    = cur;
                        holding = 1;
                    end else if (cur !== held) begin
                        hold_viol++;
                    end
                    if (bus.core_valid_o !== 1'b0) hold_viol++;
                    stall_left--;
                    bus.res_ready_i = 1'b0;
                end else if (rand_ready && $urandom_range(0, 2) == 0) begin
                    bus.res_ready_i = 1'b0;
                end else begin
                    if (holding && obs_q.size() == stall_idx && cur !== held) hold_viol++;
                    bus.res_ready_i = 1'b1;
                    obs_q.push_back(cur);
                    acc_cyc_q.push_back(e + 1);
                end
            end else begin
                bus.res_ready_i = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            e++;
        end
        bus.res_ready_i = 1'b0;
        bus.wr_en_i     = 1'b0;
        bus.start_i     = 1'b0;
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        logic [OW-1:0] outs;
        int            waited;
        reset_ni = 1'b0;
        repeat (3) @(negedge clk);
        outs = {bus.busy_o, bus.done_o, bus.core_acc_clear_o, bus.core_valid_o, bus.core_a_o, bus.core_b_o,
                bus.res_valid_o, bus.res_data_o, bus.res_row_o, bus.res_col_o};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        checks++;
        if (bus.state_dbg_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, expected 0", bus.state_dbg_o);
        end
        reset_ni = 1'b1;
        fill_random();
        load_mats();
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        waited = 0;
        while (bus.core_valid_o !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 20) begin
            errors++;
            $display("FAIL reset_reach_feed: got no core_valid_o in %0d cycles, expected FEED", waited);
        end
        @(negedge clk);
        reset_ni = 1'b0;
        #1;
        outs = {bus.busy_o, bus.done_o, bus.core_acc_clear_o, bus.core_valid_o, bus.core_a_o, bus.core_b_o,
                bus.res_valid_o, bus.res_data_o, bus.res_row_o, bus.res_col_o};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_mid_feed: got %h, expected 0", outs);
        end
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.done_o, bus.state_dbg_o} !== 5'd0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%0b done=%0b state=%0d, expected 0 0 0",
                     bus.busy_o, bus.done_o, bus.state_dbg_o);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stays_idle: got busy=%0b, expected 0", bus.busy_o);
        end
    endtask

    task automatic test_identity();
        int last;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ref_a[r*N+c] = (r == c) ? W'(1) : W'(0);
                ref_b[r*N+c] = W'(r * N + c);
            end
        end
        build_exp();
        load_mats();
        run_mult(-1, 0, 0, 0);
        checks++;
        if (timed_out || obs_q.size() != N * N) begin
            errors++;
            $display("FAIL ident_count: got %0d results (timeout=%0b), expected %0d", obs_q.size(), timed_out, N * N);
        end
        for (int n = 0; n < obs_q.size() && n < N * N; n++) begin
            checks++;
            if (obs_q[n] !== {IW'(n / N), IW'(n % N), ACC'(n)}) begin
                errors++;
                $display("FAIL ident_res[%0d]: got %h, expected %h", n, obs_q[n], {IW'(n / N), IW'(n % N), ACC'(n)});
            end
            checks++;
            if (acc_cyc_q[n] != (n + 1) * PER) begin
                errors++;
                $display("FAIL ident_timing[%0d]: got accept at %0d, expected %0d", n, acc_cyc_q[n], (n + 1) * PER);
            end
        end
        last = (acc_cyc_q.size() > 0) ? acc_cyc_q[$] : -1;
        checks++;
        if (done_cycle != N * N * PER || done_cycle != last) begin
            errors++;
            $display("FAIL ident_done_time: got done at %0d (last accept %0d), expected %0d", done_cycle, last, N * N * PER);
        end
        checks++;
        if (done_pulses != 1 || busy_viol != 0) begin
            errors++;
            $display("FAIL ident_done_pulse: got pulses=%0d busy_errs=%0d, expected 1 0", done_pulses, busy_viol);
        end
    endtask

    task automatic test_extremes();
        int lit;
        for (int pass = 0; pass < 2; pass++) begin
            for (int x = 0; x < N * N; x++) begin
                ref_a[x] = (pass == 0) ? W'(-128) : W'(127);
                ref_b[x] = W'(-128);
            end
            lit = (pass == 0) ? 65536 : -65024;
            load_mats();
            run_mult(-1, 0, 0, 0);
            checks++;
            if (timed_out || obs_q.size() != N * N) begin
                errors++;
                $display("FAIL extreme_count[%0d]: got %0d results, expected %0d", pass, obs_q.size(), N * N);
            end
            for (int n = 0; n < obs_q.size() && n < N * N; n++) begin
                checks++;
                if (obs_q[n] !== {IW'(n / N), IW'(n % N), ACC'(lit)}) begin
                    errors++;
                    $display("FAIL extreme_res[%0d][%0d]: got %h, expected %h", pass, n, obs_q[n],
                             {IW'(n / N), IW'(n % N), ACC'(lit)});
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int last;
        fill_random();
        build_exp();
        load_mats();
        run_mult(1, 10, 0, 0);
        checks++;
        if (timed_out || obs_q.size() != N * N) begin
            errors++;
            $display("FAIL bp_count: got %0d results, expected %0d", obs_q.size(), N * N);
        end
        for (int n = 0; n < obs_q.size() && n < N * N; n++) begin
            checks++;
            if (obs_q[n] !== exp_q[n]) begin
                errors++;
                $display("FAIL bp_res[%0d]: got %h, expected %h", n, obs_q[n], exp_q[n]);
            end
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable/core-active cycles, expected 0", hold_viol);
        end
        last = (acc_cyc_q.size() > 1) ? acc_cyc_q[1] : -1;
        checks++;
        if (last != 2 * PER + 10) begin
            errors++;
            $display("FAIL bp_stalled_accept: got %0d, expected %0d", last, 2 * PER + 10);
        end
        last = (acc_cyc_q.size() > 0) ? acc_cyc_q[$] : -1;
        checks++;
        if (last != N * N * PER + 10 || done_cycle != last) begin
            errors++;
            $display("FAIL bp_total: got last=%0d done=%0d, expected %0d", last, done_cycle, N * N * PER + 10);
        end
    endtask

    task automatic test_busy_writes();
        fill_random();
        ref_b[0] = W'(1);
        poke_val = ref_a[0] ^ W'(8'h55);
        build_exp();
        load_mats();
        run_mult(-1, 0, 0, 1);
        checks++;
        if (timed_out || obs_q.size() != N * N || done_pulses != 1 || busy_viol != 0) begin
            errors++;
            $display("FAIL busy_run: got results=%0d pulses=%0d busy_errs=%0d, expected %0d 1 0",
                     obs_q.size(), done_pulses, busy_viol, N * N);
        end
        for (int n = 0; n < obs_q.size() && n < N * N; n++) begin
            checks++;
            if (obs_q[n] !== exp_q[n]) begin
                errors++;
                $display("FAIL busy_res[%0d]: got %h, expected %h", n, obs_q[n], exp_q[n]);
            end
        end
        write_elem(1'b0, 0, poke_val);
        ref_a[0] = poke_val;
        build_exp();
        run_mult(-1, 0, 0, 0);
        for (int n = 0; n < obs_q.size() && n < N * N; n++) begin
            checks++;
            if (obs_q[n] !== exp_q[n]) begin
                errors++;
                $display("FAIL idle_write_res[%0d]: got %h, expected %h", n, obs_q[n], exp_q[n]);
            end
        end
        checks++;
        if (timed_out || obs_q.size() != N * N) begin
            errors++;
            $display("FAIL idle_write_count: got %0d, expected %0d", obs_q.size(), N * N);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            fill_random();
            build_exp();
            load_mats();
            run_mult(-1, 0, 1, 0);
            checks++;
            if (timed_out || obs_q.size() != N * N || done_pulses != 1) begin
                errors++;
                $display("FAIL rand_count[%0d]: got %0d results pulses=%0d, expected %0d 1",
                         it, obs_q.size(), done_pulses, N * N);
            end
            for (int n = 0; n < obs_q.size() && n < N * N; n++) begin
                checks++;
                if (obs_q[n] !== exp_q[n]) begin
                    errors++;
                    $display("FAIL rand_res[%0d][%0d]: got %h, expected %h", it, n, obs_q[n], exp_q[n]);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.wr_en_i     = 1'b0;
        bus.wr_sel_i    = 1'b0;
        bus.wr_addr_i   = '0;
        bus.wr_data_i   = '0;
        bus.start_i     = 1'b0;
        bus.res_ready_i = 1'b0;
        test_reset();
        test_identity();
        test_extremes();
        test_backpressure();
        test_busy_writes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
